// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   PC_STEP        : byte increment between sequential instruction words
//   RESET_PC_DEF   : default reset program counter
//   fetch_state_e  : fetch FSM encoding (RUN / FAULT)
//   fetch_entry_t  : one fetch-buffer entry {pc, instr}
//   pc_legal()     : word-aligned and inside the instruction memory
package instr_fetch_unit_pkg;

  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // The limit is compared at 33 bits so MEM_WORDS*4 == 2**32 still works.
  function automatic logic pc_legal(input logic [31:0] pc, input logic [32:0] limit);
    return (pc[1:0] == 2'b00) && ({1'b0, pc} < limit);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_buffer.sv
// fetch_buffer: synchronous FIFO of DEPTH fetch entries.
//   clk_i, rst_i        : clock, synchronous active-low reset
//   flush_i             : drop all entries (wins over push/pop)
//   push_i / wdata_i    : write one entry at the tail
//   pop_i               : retire the head entry
//   rdata_o             : head entry (zero after reset, never X)
//   count_o, full_o, empty_o : occupancy
// The caller guarantees push only when !full or popping, pop only when !empty.
module fetch_buffer
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fetch_entry_t             wdata_i,
  input  logic                     pop_i,
  output fetch_entry_t             rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      // Storage contents are left alone; only the bookkeeping is cleared.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = wr_ptr_q + 1'b1;  // power-of-two depth: natural wrap
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, drives the instruction memory address and
// buffers returned words for decode.
//   clk_i, rst_i          : clock, synchronous active-low reset
//   pc_addr_o             : byte address to memory (current PC)
//   instr_i               : combinational memory response for pc_addr_o
//   redirect_i/_pc_i      : load a new PC and flush the buffer
//   instr_o/instr_pc_o    : buffer head word and its PC
//   valid_o / ready_i     : decode handshake
//   fault_o               : fetch halted on an illegal PC
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          MEM_WORDS = 32,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] pc_addr_o,
  input  logic [31:0] instr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        fault_o
);

  localparam logic [32:0] PC_LIMIT = 33'(MEM_WORDS) * 33'd4;

  logic [31:0]  pc_q, pc_d;
  fetch_state_e state_q, state_d;

  fetch_entry_t wr_entry, head;
  logic         push, pop, legal, full, empty;
  logic [$clog2(BUF_DEPTH):0] count;

  assign legal = pc_legal(pc_q, PC_LIMIT);
  assign pop   = valid_o & ready_i;
  // A full buffer still accepts a word when the head leaves in the same cycle.
  assign push  = (state_q == ST_RUN) & legal & ~redirect_i & (~full | pop);

  assign wr_entry.pc    = pc_q;
  assign wr_entry.instr = instr_i;

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign pc_addr_o  = pc_q;
  assign valid_o    = ~empty;
  assign instr_o    = head.instr;
  assign instr_pc_o = head.pc;
  assign fault_o    = (state_q == ST_FAULT);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_i) begin
      // Legality of the target is judged next cycle from the new PC.
      pc_d    = redirect_pc_i;
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!legal)    state_d = ST_FAULT;
          else if (push) pc_d    = pc_q + PC_STEP;
        end
        default: ;  // FAULT: PC frozen until redirect or reset
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc_q    <= RESET_PC;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_addr_o;
  logic [31:0] instr_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        valid_o;
  logic        ready_i;
  logic        fault_o;

  int tests = 0;
  int fails = 0;

  instr_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .MEM_WORDS (32),
    .BUF_DEPTH (2)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .pc_addr_o     (pc_addr_o),
    .instr_i       (instr_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .fault_o       (fault_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory model: word n holds 32'h1000_0000 + n.
  assign instr_i = 32'h1000_0000 + {2'b00, pc_addr_o[31:2]};

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; ready_i = 1'b0;
    step(); step();
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_fault", {31'd0, fault_o}, 32'd0);
    check("rst_pc", pc_addr_o, 32'h0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_ipc", instr_pc_o, 32'h0);

    // Streaming with ready high
    rst_i = 1'b1; ready_i = 1'b1;
    check("s_pc0", pc_addr_o, 32'h0);
    step();
    check("s_valid", {31'd0, valid_o}, 32'd1);
    check("s_instr0", instr_o, 32'h1000_0000);
    check("s_ipc0", instr_pc_o, 32'h0);
    check("s_pc4", pc_addr_o, 32'h4);
    for (int k = 1; k <= 3; k++) begin
      step();
      check("s_ipc", instr_pc_o, 32'(4 * k));
      check("s_instr", instr_o, 32'h1000_0000 + 32'(k));
    end

    // Backpressure
    rst_i = 1'b0; step();
    rst_i = 1'b1; ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("bp_pc_hold", pc_addr_o, 32'h8);
    check("bp_valid", {31'd0, valid_o}, 32'd1);
    check("bp_head0", instr_pc_o, 32'h0);
    ready_i = 1'b1;
    step();
    check("bp_head4", instr_pc_o, 32'h4);
    step();
    check("bp_head8", instr_pc_o, 32'h8);
    check("bp_instr8", instr_o, 32'h1000_0002);

    // Redirect with two entries buffered
    ready_i = 1'b0;
    step();
    check("rd_pc_hold", pc_addr_o, 32'h10);
    redirect_i = 1'b1; redirect_pc_i = 32'h40;
    step();
    check("rd_flush_valid", {31'd0, valid_o}, 32'd0);
    check("rd_pc", pc_addr_o, 32'h40);
    redirect_i = 1'b0;
    step();
    check("rd_valid", {31'd0, valid_o}, 32'd1);
    check("rd_ipc", instr_pc_o, 32'h40);
    check("rd_instr", instr_o, 32'h1000_0010);

    // Run to end of memory
    ready_i = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      step();
      check("end_ipc", instr_pc_o, 32'h40 + 32'(4 * k));
    end
    ready_i = 1'b0;
    step();
    check("end_pc7c", pc_addr_o, 32'h7C);
    ready_i = 1'b1;
    step();
    check("end_pc80", pc_addr_o, 32'h80);
    check("end_nofault", {31'd0, fault_o}, 32'd0);
    check("end_head78", instr_pc_o, 32'h78);
    ready_i = 1'b0;
    step();
    check("end_fault", {31'd0, fault_o}, 32'd1);
    check("end_valid", {31'd0, valid_o}, 32'd1);
    check("end_pc_stick", pc_addr_o, 32'h80);
    ready_i = 1'b1;
    step();
    check("end_drain7c", instr_pc_o, 32'h7C);
    check("end_drain_instr", instr_o, 32'h1000_001F);
    step();
    check("end_empty", {31'd0, valid_o}, 32'd0);
    check("end_fault2", {31'd0, fault_o}, 32'd1);
    check("end_pc80b", pc_addr_o, 32'h80);
    redirect_i = 1'b1; redirect_pc_i = 32'h0;
    step();
    check("rec_fault", {31'd0, fault_o}, 32'd0);
    check("rec_pc", pc_addr_o, 32'h0);
    redirect_i = 1'b0;
    step();
    check("rec_valid", {31'd0, valid_o}, 32'd1);
    check("rec_ipc", instr_pc_o, 32'h0);

    // Misaligned redirect
    redirect_i = 1'b1; redirect_pc_i = 32'h2;
    step();
    check("mis_pc", pc_addr_o, 32'h2);
    check("mis_fault0", {31'd0, fault_o}, 32'd0);
    check("mis_valid0", {31'd0, valid_o}, 32'd0);
    redirect_i = 1'b0;
    step();
    check("mis_fault1", {31'd0, fault_o}, 32'd1);
    check("mis_valid1", {31'd0, valid_o}, 32'd0);
    step();
    check("mis_valid2", {31'd0, valid_o}, 32'd0);
    check("mis_pc_hold", pc_addr_o, 32'h2);

    // Reset overrides redirect with entries buffered
    redirect_i = 1'b1; redirect_pc_i = 32'h0;
    step();
    redirect_i = 1'b0; ready_i = 1'b0;
    step(); step();
    check("mr_pc8", pc_addr_o, 32'h8);
    check("mr_valid", {31'd0, valid_o}, 32'd1);
    rst_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h40; ready_i = 1'b1;
    step();
    check("mr_valid0", {31'd0, valid_o}, 32'd0);
    check("mr_fault0", {31'd0, fault_o}, 32'd0);
    check("mr_pc", pc_addr_o, 32'h0);
    check("mr_instr", instr_o, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch-side initiator for the word-addressed instruction memory. It owns the program counter, drives the byte address to the memory, and captures each returned word together with its PC into a small fetch buffer. It presents fetched instructions to decode through a valid/ready handshake. It supports branch/jump redirect with flush, and flags out-of-range or misaligned PCs.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MEM_WORDS, 32, instruction memory depth in 32-bit words; legal byte range is 0 .. MEM_WORDS*4-4
BUF_DEPTH, 2, fetch buffer entries (power of two, >=2)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  reset, synchronous, active-low
pc_addr_o  output  32  byte address to instruction memory, equals current PC register
instr_i  input  32  instruction word from memory; combinational response to pc_addr_o, valid in the same cycle
redirect_i  input  1  load redirect_pc_i as new PC and flush buffer
redirect_pc_i  input  32  redirect target byte address
instr_o  output  32  instruction at buffer head
instr_pc_o  output  32  PC of instr_o
valid_o  output  1  buffer head holds a valid entry
ready_i  input  1  decode accepts head this cycle
fault_o  output  1  fetch halted on illegal PC

Behaviour:
- Reset (rst_i=0 at edge): pc=RESET_PC, buffer count=0, rd/wr pointers=0, state=RUN, valid_o=0, instr_o=0, instr_pc_o=0, fault_o=0. Reset overrides redirect and handshake in the same cycle.
- States: RUN, FAULT. fault_o = (state==FAULT).
- Legality of pc: pc[1:0]==0 and pc < MEM_WORDS*4.
- pop = valid_o & ready_i.
- push = (state==RUN) & legal(pc) & !redirect_i & (count<BUF_DEPTH | pop).
- On push: write {pc, instr_i} at wr pointer; pc <= pc+4 (32-bit wrap, no carry out).
- On pop: advance rd pointer. count updates by push-pop; simultaneous push and pop when full is allowed, count unchanged.
- RUN with pc illegal and no redirect: no push, state->FAULT, pc holds. Entries already buffered remain poppable.
- Redirect (any state): flush buffer (count=0, pointers=0, valid_o=0 next cycle), pc <= redirect_pc_i, no push that cycle. Any pop that cycle is accepted but flushed regardless. State->RUN; a target that is illegal re-enters FAULT the following cycle.
- FAULT: no pushes; pc frozen; leaves only via redirect or reset.
- Latency: the word at PC p is on instr_o, valid_o=1, one edge after pc_addr_o==p with push true. Steady state with ready_i=1 gives one instruction per cycle.
- Outputs instr_o and instr_pc_o come from the buffer head. Their values while valid_o=0 are don't-care but must not be X after reset.
- Memory index used by the memory is pc/4. This block never issues an address outside the legal range while pushing.

Decomposition:
- Shared package: PC_STEP=4, RESET_PC default, state encoding (RUN=1'b0, FAULT=1'b1), fetch-entry layout {pc[31:0], instr[31:0]} as a 64-bit packed type.
- One sub-module: fetch_buffer, a synchronous FIFO of BUF_DEPTH x 64 bits with push/pop/flush, count, full/empty. Same clk_i/rst_i.
- Top holds the PC register, legality check, FSM and handshake glue.

Test Plan:
- Reset release, memory word n = 32'h1000_0000+n, ready_i=1 -> pc_addr_o=0 on first cycle; valid_o rises next cycle with instr_o=32'h1000_0000, instr_pc_o=0; then PCs 4, 8, 12 on consecutive cycles.
- Backpressure: ready_i=0 for 5 cycles after first fetch -> count reaches 2, pc_addr_o holds at 8. Release -> output sequence PC 0, 4, 8 with no loss or duplication.
- Redirect to 32'h40 while 2 entries buffered and ready_i=0 -> next cycle valid_o=0; following cycle instr_pc_o=32'h40, instr_o=word 16.
- Run to end with MEM_WORDS=32 -> last pushed PC 32'h7C; pc_addr_o sticks at 32'h80; fault_o=1; buffered entries still drain. Redirect to 0 -> fault_o=0, fetch restarts at PC 0.
- Misaligned redirect to 32'h2 -> no push; fault_o=1 one cycle after redirect; valid_o stays 0.
- rst_i=0 mid-stream with 2 entries buffered and redirect_i=1 -> next cycle valid_o=0, fault_o=0, pc_addr_o=RESET_PC.
